contador_m_redux_invertible: RTL and testbench
==============================================

CONTADOR_M_REDUX_INVERTIBLE -- requirements
Module: contador_m_redux_invertible

Interface
REQ-001 Parameter M, default 64, nominal (maximum) modulus; SHALL satisfy 2 <= M <= 2^N.
REQ-002 Parameter N, default 7, width of Q.
REQ-003 Parameter SCORE_N, default 4, width of score.
REQ-004 Parameter MIN_M, default 8, minimum modulus at maximum score; SHALL satisfy 1 <= MIN_M <= M.
REQ-005 clock  input  1  sole clock; all state SHALL change on its rising edge, except asynchronous reset.
REQ-006 zera_as  input  1  asynchronous, active-high reset.
REQ-007 zera_s  input  1  synchronous clear, active high.
REQ-008 conta  input  1  count enable.
REQ-009 score  input  SCORE_N  modulus-reduction control, unsigned.
REQ-010 count_up  input  1  direction: 1 = up, 0 = down.
REQ-011 Q  output  N  current count.
REQ-012 fim  output  1  end flag, combinational from Q and M_eff.
REQ-013 inicio  output  1  start flag, combinational from Q.

Function
REQ-014 Effective modulus SHALL be M_eff = M - floor(score*(M-MIN_M)/(2^SCORE_N-1)), giving M at score 0 and MIN_M at score 2^SCORE_N-1.
REQ-015 Arithmetic SHALL use at least N+SCORE_N bits internally, with no overflow for any legal parameter set.
REQ-016 Priority per cycle: zera_as > zera_s > conta; zera_s=1 SHALL load Q=0 on the next edge, regardless of conta.
REQ-017 conta=0 (and no clear) SHALL hold Q.
REQ-018 conta=1, count_up=1: Q SHALL become Q+1 if Q < M_eff-1, else 0.
REQ-019 conta=1, count_up=0: Q SHALL become Q-1 if 0 < Q <= M_eff-1; if Q=0 it SHALL become M_eff-1.
REQ-020 Out of range (Q >= M_eff after score increase): counting up SHALL load 0; counting down SHALL load M_eff-1.
REQ-021 fim SHALL be 1 exactly when Q == M_eff-1, independent of count_up and conta.
REQ-022 inicio SHALL be 1 exactly when Q == 0, independent of count_up and conta.
REQ-023 With M_eff=1, Q SHALL stay 0 and fim and inicio SHALL both be 1.
REQ-024 Changes to count_up or score SHALL take effect at the next rising edge, with no extra latency.

Reset
REQ-025 zera_as=1 SHALL force Q=0 immediately, regardless of clock; hence inicio=1, and fim=1 only if M_eff=1.
REQ-026 Release of zera_as SHALL not alter Q; counting resumes at the first edge with conta=1.
REQ-027 zera_s asserted mid-count SHALL override a pending wrap in either direction.

Configuration
REQ-028 Macro CONTADOR_SCORE_LATCH_EN: when defined, score SHALL be sampled into an internal register only on reset, on zera_s, and on the cycle Q wraps (up: Q M_eff-1 -> 0; down: Q 0 -> M_eff-1). M_eff, fim and wrap decisions SHALL use the latched value, and REQ-020 becomes unreachable.
REQ-029 When CONTADOR_SCORE_LATCH_EN is undefined, M_eff SHALL follow score combinationally, per REQ-014.

Structure
REQ-030 A shared package SHALL hold the M_eff computation function and derived constants (score maximum 2^SCORE_N-1, M-MIN_M span).
REQ-031 One sub-module, redux_modulus, SHALL compute M_eff-1 from score. Next-state, register and flag logic SHALL live in the top module.

Verification
REQ-032 Assert zera_as for 10 ns, then score=0, count_up=1, conta=1 for 40 cycles -> Q = 0..39 in order; inicio only at Q=0; no fim.
REQ-033 Continue with score=0, count_up=1 to cycle 64 -> fim=1 at Q=63; next Q=0 with inicio=1.
REQ-034 From Q=0, switch to count_up=0 at score=0 -> next Q=63 (fim=1), then 62, 61, ...
REQ-035 score=3 (M_eff=53), count_up=0, starting at Q=60 -> without latch macro next Q=52; with latch macro decrement continues under the old modulus until wrap.
REQ-036 score=15 (M_eff=8), count_up=1, 80 cycles -> Q cycles 0..7; fim at Q=7 every 8 cycles; inicio at Q=0.
REQ-037 zera_s=1 with conta=1 at Q=5 -> Q=0 next edge; zera_as asserted mid-cycle -> Q=0 immediately.

Source files
------------

// File: rtl/contador_m_redux_invertible_pkg.sv
// contador_m_redux_invertible_pkg: effective-modulus arithmetic shared by the counter and its modulus reducer.
// All arithmetic is 64-bit so no legal parameter set can overflow.
package contador_m_redux_invertible_pkg;

    function automatic longint unsigned score_max(input int score_n);
        return (64'd1 << score_n) - 64'd1;
    endfunction

    function automatic longint unsigned span(input longint unsigned m, input longint unsigned min_m);
        return m - min_m;
    endfunction

    // M at score 0, MIN_M at full score, linear floor in between
    function automatic longint unsigned m_eff(input longint unsigned m, input longint unsigned min_m,
                                              input longint unsigned score, input int score_n);
        return m - (score * span(m, min_m)) / score_max(score_n);
    endfunction

endpackage

// File: rtl/redux_modulus.sv
// redux_modulus: maps score to the terminal count M_eff-1 of the counter.
module redux_modulus
    import contador_m_redux_invertible_pkg::*;
#(
    parameter int M       = 64,
    parameter int N       = 7,
    parameter int SCORE_N = 4,
    parameter int MIN_M   = 8
) (
    input  logic [SCORE_N-1:0] score,
    output logic [N-1:0]       top
);

    assign top = N'(m_eff(64'(M), 64'(MIN_M), 64'(score), SCORE_N) - 64'd1);

endmodule

// File: rtl/contador_m_redux_invertible.sv
// contador_m_redux_invertible: up/down counter whose modulus shrinks with score.
// CONTADOR_SCORE_LATCH_EN: score only takes effect after reset, zera_s or a wrap.
module contador_m_redux_invertible
    import contador_m_redux_invertible_pkg::*;
#(
    parameter int M       = 64,
    parameter int N       = 7,
    parameter int SCORE_N = 4,
    parameter int MIN_M   = 8
) (
    input  logic               clock,
    input  logic               zera_as,
    input  logic               zera_s,
    input  logic               conta,
    input  logic [SCORE_N-1:0] score,
    input  logic               count_up,
    output logic [N-1:0]       Q,
    output logic               fim,
    output logic               inicio
);

    logic [N-1:0]       top;
    logic [SCORE_N-1:0] eff_score;

`ifdef CONTADOR_SCORE_LATCH_EN
    logic               primed;
    logic [SCORE_N-1:0] score_q;
    logic               wrap;

    // Until the first edge after reset the live score stands in for the sample
    assign eff_score = primed ? score_q : score;
    assign wrap      = conta && !zera_s && (count_up ? Q == top : Q == '0);

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            primed  <= 1'b0;
            score_q <= '0;
        end else if (!primed || zera_s || wrap) begin
            primed  <= 1'b1;
            score_q <= score;
        end
    end
`else
    assign eff_score = score;
`endif

    redux_modulus #(.M(M), .N(N), .SCORE_N(SCORE_N), .MIN_M(MIN_M)) u_redux (
        .score (eff_score),
        .top   (top)
    );

    // Q above top (score just rose) snaps to the wrap target of the direction
    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as)
            Q <= '0;
        else if (zera_s)
            Q <= '0;
        else if (conta)
            Q <= count_up ? (Q < top ? Q + 1'b1 : '0)
                          : (Q == '0 || Q > top ? top : Q - 1'b1);
    end

    assign fim    = Q == top;
    assign inicio = Q == '0;

endmodule

// File: tb/tb_contador_m_redux_invertible.sv
// tb_contador_m_redux_invertible: randomized and directed checks against a modular-arithmetic model.
module tb_contador_m_redux_invertible;

    localparam int M = 64, N = 7, SN = 4, MIN_M = 8;

    logic          clock = 1'b0;
    logic          zera_as = 1'b1, zera_s = 1'b0, conta = 1'b0, count_up = 1'b1;
    logic [SN-1:0] score = '0;
    logic [N-1:0]  Q;
    logic          fim, inicio;

    int vectors = 0, miscompares = 0;
    int mq = 0, ls = 0;
    bit primed = 0;

    contador_m_redux_invertible #(.M(M), .N(N), .SCORE_N(SN), .MIN_M(MIN_M)) dut (
        .clock (clock), .zera_as (zera_as), .zera_s (zera_s), .conta (conta),
        .score (score), .count_up (count_up), .Q (Q), .fim (fim), .inicio (inicio)
    );

    always #5 clock = ~clock;

    function automatic int meff(input int s);
        return M - (s * (M - MIN_M)) / ((1 << SN) - 1);
    endfunction

    function automatic int cur_score();
`ifdef CONTADOR_SCORE_LATCH_EN
        return primed ? ls : int'(score);
`else
        return int'(score);
`endif
    endfunction

    function automatic bit exp_fim();
        return mq == meff(cur_score()) - 1;
    endfunction

    // One rising edge: model moves modulo M_eff, then wait for the sampling edge
    task automatic step();
        int me, old;
        bit wrapped;
        @(posedge clock);
        me = meff(cur_score());
        old = mq;
        if (zera_s) mq = 0;
        else if (conta) begin
            if (old >= me) mq = count_up ? 0 : me - 1;
            else mq = count_up ? (old + 1) % me : (old + me - 1) % me;
        end
        wrapped = !zera_s && conta && old < me && (count_up ? old == me - 1 : old == 0);
        if (!primed || zera_s || wrapped) ls = int'(score);
        primed = 1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #10;
        mq = 0; primed = 0;
        vectors++;
        if ({Q, fim, inicio} !== {7'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset Q=%0d fim=%b inicio=%b want Q=0 fim=0 inicio=1", Q, fim, inicio);
        end
        zera_as = 0;
    endtask

    task automatic test_count_up();
        score = 0; count_up = 1; conta = 1;
        for (int i = 1; i <= 70; i++) begin
            step();
            vectors++;
            if ({Q, fim, inicio} !== {7'(i % 64), (i % 64) == 63, (i % 64) == 0}) begin
                miscompares++;
                $display("FAIL count_up i=%0d Q=%0d fim=%b inicio=%b want Q=%0d", i, Q, fim, inicio, i % 64);
            end
        end
    endtask

    task automatic test_count_down();
        zera_s = 1; step(); zera_s = 0;
        count_up = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if ({Q, fim, inicio} !== {7'(63 - i), i == 0, 1'b0}) begin
                miscompares++;
                $display("FAIL count_down i=%0d Q=%0d fim=%b inicio=%b want Q=%0d", i, Q, fim, inicio, 63 - i);
            end
        end
    endtask

    task automatic test_out_of_range();
        zera_s = 1; step(); zera_s = 0;
        count_up = 1; score = 0;
        for (int i = 0; i < 60; i++) step();
        vectors++;
        if (Q !== 7'd60) begin
            miscompares++;
            $display("FAIL oor_setup Q=%0d want 60", Q);
        end
        score = 3; count_up = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({Q, fim, inicio} !== {7'(mq), exp_fim(), mq == 0}) begin
                miscompares++;
                $display("FAIL out_of_range i=%0d Q=%0d fim=%b want Q=%0d fim=%b", i, Q, fim, mq, exp_fim());
            end
`ifndef CONTADOR_SCORE_LATCH_EN
            if (i == 0) begin
                vectors++;
                if ({Q, fim} !== {7'd52, 1'b1}) begin
                    miscompares++;
                    $display("FAIL oor_load Q=%0d fim=%b want Q=52 fim=1", Q, fim);
                end
            end
`endif
        end
    endtask

    task automatic test_min_modulus();
        zera_s = 1; step(); zera_s = 0;
        score = 15; count_up = 1;
        for (int i = 1; i <= 80; i++) begin
            step();
            vectors++;
            if ({Q, fim, inicio} !== {7'(mq), exp_fim(), mq == 0}) begin
                miscompares++;
                $display("FAIL min_modulus i=%0d Q=%0d fim=%b inicio=%b want Q=%0d", i, Q, fim, inicio, mq);
            end
`ifndef CONTADOR_SCORE_LATCH_EN
            vectors++;
            if ({Q, fim} !== {7'(i % 8), (i % 8) == 7}) begin
                miscompares++;
                $display("FAIL min_mod_seq i=%0d Q=%0d fim=%b want Q=%0d", i, Q, fim, i % 8);
            end
`endif
        end
    endtask

    task automatic test_clear();
        zera_s = 1; step(); zera_s = 0;
        score = 0; count_up = 1;
        for (int i = 0; i < 5; i++) step();
        zera_s = 1; step(); zera_s = 0;
        vectors++;
        if ({Q, inicio} !== {7'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL sync_clear Q=%0d inicio=%b want Q=0 inicio=1", Q, inicio);
        end
        for (int i = 0; i < 3; i++) step();
        #2 zera_as = 1;
        #1 mq = 0; primed = 0;
        vectors++;
        if ({Q, inicio} !== {7'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_clear Q=%0d inicio=%b want Q=0 inicio=1", Q, inicio);
        end
        zera_as = 0;
        @(negedge clock);
        // clear wins over a pending wrap: down at Q=0 and up at Q=top
        count_up = 0; zera_s = 1; step(); zera_s = 0;
        vectors++;
        if (Q !== 7'd0) begin
            miscompares++;
            $display("FAIL clear_wrap_down Q=%0d want 0", Q);
        end
        step();
        count_up = 1; zera_s = 1; step(); zera_s = 0;
        vectors++;
        if ({Q, inicio} !== {7'(mq), 1'b1} || mq != 0) begin
            miscompares++;
            $display("FAIL clear_wrap_up Q=%0d want 0", Q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            conta = $urandom_range(3) != 0;
            count_up = $urandom_range(1) == 1;
            zera_s = $urandom_range(20) == 0;
            if ($urandom_range(10) == 0) score = SN'($urandom_range(15));
            step();
            vectors++;
            if ({Q, fim, inicio} !== {7'(mq), exp_fim(), mq == 0}) begin
                miscompares++;
                $display("FAIL random i=%0d score=%0d Q=%0d fim=%b inicio=%b want Q=%0d fim=%b",
                         i, score, Q, fim, inicio, mq, exp_fim());
            end
        end
        zera_s = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_out_of_range();
        test_min_modulus();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
